ps2_led_cmd_sequencer: RTL and testbench

//  Host-to-keyboard command sequencer sitting between the PS/2 byte interface and the scancode decoder.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_reply_timer.sv | 35 +++
 rtl/ps2_led_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_led_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-command constants and sequencer state encoding.
// Init states are only reachable when PS2_INIT_RESET_EN is defined.
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK      = 8'hAA;

    // The BAT reply can take far longer than a normal ACK.
    localparam int unsigned BAT_TIMEOUT_MULT = 50;

    typedef enum logic [2:0] {
        StIdle,
        StTxCmd,
        StWaitAck1,
        StTxArg,
        StWaitAck2,
        StInitTx,
        StInitAck,
        StInitBat
    } ps2_seq_state_t;

    function automatic logic is_wait_state(input ps2_seq_state_t s);
        return (s == StWaitAck1) || (s == StWaitAck2) || (s == StInitAck) || (s == StInitBat);
    endfunction

endpackage

// File: rtl/ps2_reply_timer.sv
// Reply timeout counter: counts while enabled, saturates at the terminal count
// and flags expiry for as long as it sits there.
module ps2_reply_timer #(
    parameter int unsigned TMR_W = 20
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [TMR_W-1:0] terminal_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q < terminal_i)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == terminal_i);

endmodule

// File: rtl/ps2_led_cmd_sequencer.sv
// Host-to-keyboard Set-LEDs sequencer with ACK/RESEND retry, reply timeout and byte forwarding.
// Define PS2_INIT_RESET_EN to run a keyboard reset (0xFF, ACK, BAT) after every reset.
module ps2_led_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 400000,
    parameter int unsigned TMR_W          = 20,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       led_req_i,
    input  logic [2:0] led_val_i,
    output logic       led_busy_o,
    output logic       led_done_o,
    output logic       led_err_o,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [7:0] fwd_data_o,
    output logic       fwd_valid_o,
    output logic       init_done_o
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);
    localparam logic [TMR_W-1:0] TmrTerminal = TMR_W'(TIMEOUT_CYCLES - 1);

    ps2_seq_state_t    state_q;
    logic [2:0]        led_val_q;
    logic [RetryW-1:0] retry_q;
    logic              led_busy_q, led_done_q, led_err_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic [7:0]        fwd_data_q;
    logic              fwd_valid_q;
    logic              init_done;
    logic              tmr_expire, tmr_clear, bat_wrap;

`ifdef PS2_INIT_RESET_EN
    localparam logic [5:0] BatLast = 6'(BAT_TIMEOUT_MULT - 1);
    logic [5:0] bat_cnt_q;
    logic       init_done_q;

    assign init_done = init_done_q;
    // BAT window is the base timeout repeated; restart the timer until the last lap.
    assign bat_wrap  = tmr_expire && (state_q == StInitBat) && (bat_cnt_q != BatLast);
`else
    assign init_done = 1'b1;
    assign bat_wrap  = 1'b0;
`endif

    assign tmr_clear = !is_wait_state(state_q) || bat_wrap;

    ps2_reply_timer #(
        .TMR_W (TMR_W)
    ) u_reply_timer (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .clear_i    (tmr_clear),
        .en_i       (is_wait_state(state_q)),
        .terminal_i (TmrTerminal),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
`ifdef PS2_INIT_RESET_EN
            state_q     <= StInitTx;
            bat_cnt_q   <= '0;
            init_done_q <= 1'b0;
`else
            state_q     <= StIdle;
`endif
            led_val_q   <= '0;
            retry_q     <= '0;
            led_busy_q  <= 1'b0;
            led_done_q  <= 1'b0;
            led_err_q   <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            fwd_data_q  <= '0;
            fwd_valid_q <= 1'b0;
        end else begin
            led_done_q  <= 1'b0;
            led_err_q   <= 1'b0;
            fwd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rx_valid_i) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= rx_data_i;
                    end
                    if (led_req_i && init_done) begin
                        led_val_q  <= led_val_i;
                        led_busy_q <= 1'b1;
                        retry_q    <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= PS2_CMD_SET_LED;
                        state_q    <= StTxCmd;
                    end
                end
                StTxCmd, StTxArg: begin
                    if (rx_valid_i) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= rx_data_i;
                    end
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= (state_q == StTxCmd) ? StWaitAck1 : StWaitAck2;
                    end
                end
                StWaitAck1, StWaitAck2: begin
                    if (rx_valid_i && (rx_data_i == PS2_ACK)) begin
                        retry_q <= '0;
                        if (state_q == StWaitAck1) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= {5'b0, led_val_q};
                            state_q    <= StTxArg;
                        end else begin
                            led_done_q <= 1'b1;
                            led_busy_q <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end else if (rx_valid_i && (rx_data_i == PS2_RESEND)) begin
                        if (retry_q < MaxRetry) begin
                            // tx_data_q still holds the byte being resent.
                            retry_q    <= retry_q + 1'b1;
                            tx_valid_q <= 1'b1;
                            state_q    <= (state_q == StWaitAck1) ? StTxCmd : StTxArg;
                        end else begin
                            retry_q    <= '0;
                            led_err_q  <= 1'b1;
                            led_busy_q <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end else if (rx_valid_i) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= rx_data_i;
                    end else if (tmr_expire) begin
                        retry_q    <= '0;
                        led_err_q  <= 1'b1;
                        led_busy_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
`ifdef PS2_INIT_RESET_EN
                StInitTx: begin
                    if (rx_valid_i) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= rx_data_i;
                    end
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= PS2_CMD_RESET;
                    end else if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StInitAck;
                    end
                end
                StInitAck: begin
                    if (rx_valid_i && (rx_data_i == PS2_ACK)) begin
                        retry_q   <= '0;
                        bat_cnt_q <= '0;
                        state_q   <= StInitBat;
                    end else if (rx_valid_i && (rx_data_i == PS2_RESEND)) begin
                        if (retry_q < MaxRetry) begin
                            retry_q    <= retry_q + 1'b1;
                            tx_valid_q <= 1'b1;
                            state_q    <= StInitTx;
                        end else begin
                            retry_q     <= '0;
                            led_err_q   <= 1'b1;
                            init_done_q <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end else if (rx_valid_i) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= rx_data_i;
                    end else if (tmr_expire) begin
                        retry_q     <= '0;
                        led_err_q   <= 1'b1;
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StInitBat: begin
                    if (rx_valid_i && (rx_data_i == PS2_BAT_OK)) begin
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end else if (rx_valid_i && (rx_data_i != PS2_ACK)) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= rx_data_i;
                    end else if (!rx_valid_i && bat_wrap) begin
                        bat_cnt_q <= bat_cnt_q + 1'b1;
                    end else if (!rx_valid_i && tmr_expire) begin
                        led_err_q   <= 1'b1;
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
`endif
                default: begin
                    tx_valid_q <= 1'b0;
                    led_busy_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign led_busy_o  = led_busy_q;
    assign led_done_o  = led_done_q;
    assign led_err_o   = led_err_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign fwd_data_o  = fwd_data_q;
    assign fwd_valid_o = fwd_valid_q;
    assign init_done_o = init_done;

endmodule

// File: tb/tb_ps2_led_cmd_sequencer.sv
// Directed bench for ps2_led_cmd_sequencer: cycle vector table plus retry/timeout/stall/reset sequences.
// Also exercises the keyboard init sequence when PS2_INIT_RESET_EN is defined.
module tb_ps2_led_cmd_sequencer;

    localparam int unsigned TO = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic       led_busy, led_done, led_err, tx_valid, fwd_valid, init_done;
    logic [7:0] tx_data, fwd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ed    = 0;

    ps2_led_cmd_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .TMR_W          (8),
        .MAX_RETRY      (3)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .led_req_i   (led_req),
        .led_val_i   (led_val),
        .led_busy_o  (led_busy),
        .led_done_o  (led_done),
        .led_err_o   (led_err),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .fwd_data_o  (fwd_data),
        .fwd_valid_o (fwd_valid),
        .init_done_o (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_valid && tx_ready && tx_data == 8'hED) n_ed++;
    end

    typedef struct {
        logic       req;
        logic [2:0] val;
        logic       rxv;
        logic [7:0] rxd;
        logic       rdy;
        logic       tv;
        logic [7:0] td;
        logic       busy;
        logic       done;
        logic       err;
        logic       fv;
        logic [7:0] fd;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic req, input logic [2:0] val, input logic rxv,
                                input logic [7:0] rxd, input logic rdy, input logic tv,
                                input logic [7:0] td, input logic busy, input logic done,
                                input logic err, input logic fv, input logic [7:0] fd);
        vec_t v;
        v.req = req; v.val = val; v.rxv = rxv; v.rxd = rxd; v.rdy = rdy;
        v.tv = tv; v.td = td; v.busy = busy; v.done = done; v.err = err; v.fv = fv; v.fd = fd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tx(input string name, input logic [7:0] b);
        int i = 0;
        while (!tx_valid && i < 200) begin
            tick();
            i++;
        end
        check(name, {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, b});
        tick();
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_req(input logic [2:0] v);
        led_val = v;
        led_req = 1'b1;
        tick();
        led_req = 1'b0;
    endtask

    task automatic post_reset();
`ifdef PS2_INIT_RESET_EN
        check("init_done_low", {31'h0, init_done}, 32'h0);
        start_req(3'b111);
        check("req_ignored_init", {31'h0, led_busy}, 32'h0);
        wait_tx("init_tx_ff", 8'hFF);
        send_rx(8'hFA);
        check("init_after_ack", {31'h0, init_done}, 32'h0);
        send_rx(8'hAA);
        check("init_done_bat", {31'h0, init_done}, 32'h1);
        check("init_no_busy", {31'h0, led_busy}, 32'h0);
`else
        check("init_done_tied", {31'h0, init_done}, 32'h1);
`endif
    endtask

    initial begin
        int n0;
        logic err_early, stable;
        logic [20:0] got, exp;

        //             req val     rxv rxd    rdy tv td     busy done err fv fd
        vecs[0]  = mk(1, 3'b101, 0, 8'h00, 1, 1, 8'hED, 1, 0, 0, 0, 8'h00);
        vecs[1]  = mk(0, 3'b000, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[2]  = mk(0, 3'b000, 1, 8'hFA, 1, 1, 8'h05, 1, 0, 0, 0, 8'h00);
        vecs[3]  = mk(0, 3'b000, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[4]  = mk(0, 3'b000, 1, 8'hFA, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00);
        vecs[5]  = mk(0, 3'b000, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        vecs[6]  = mk(0, 3'b000, 1, 8'hFA, 1, 0, 8'h00, 0, 0, 0, 1, 8'hFA);
        vecs[7]  = mk(1, 3'b011, 0, 8'h00, 1, 1, 8'hED, 1, 0, 0, 0, 8'h00);
        vecs[8]  = mk(1, 3'b111, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[9]  = mk(0, 3'b000, 1, 8'h1C, 1, 0, 8'h00, 1, 0, 0, 1, 8'h1C);
        vecs[10] = mk(0, 3'b000, 1, 8'hFA, 1, 1, 8'h03, 1, 0, 0, 0, 8'h00);
        vecs[11] = mk(0, 3'b000, 0, 8'h00, 0, 1, 8'h03, 1, 0, 0, 0, 8'h00);
        vecs[12] = mk(0, 3'b000, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[13] = mk(0, 3'b000, 1, 8'h55, 1, 0, 8'h00, 1, 0, 0, 1, 8'h55);
        vecs[14] = mk(0, 3'b000, 1, 8'hFA, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00);
        vecs[15] = mk(0, 3'b000, 1, 8'hFE, 1, 0, 8'h00, 0, 0, 0, 1, 8'hFE);

        // Reset state
        repeat (3) tick();
        check("reset_outputs",
              {24'h0, tx_valid, led_busy, led_done, led_err, fwd_valid, 3'b0},
              32'h0);
        check("reset_data", {16'h0, tx_data, fwd_data}, 32'h0);
        reset_n = 1'b1;
        tick();
        post_reset();

        // Cycle-by-cycle vector table
        for (int i = 0; i < 16; i++) begin
            led_req  = vecs[i].req;
            led_val  = vecs[i].val;
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            tx_ready = vecs[i].rdy;
            tick();
            got = {tx_valid, (vecs[i].tv ? tx_data : 8'h00), led_busy, led_done, led_err,
                   fwd_valid, (vecs[i].fv ? fwd_data : 8'h00)};
            exp = {vecs[i].tv, vecs[i].td, vecs[i].busy, vecs[i].done, vecs[i].err,
                   vecs[i].fv, vecs[i].fd};
            check($sformatf("vec%0d", i), {11'h0, got}, {11'h0, exp});
        end
        led_req  = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick();

        // Two resends of 0xED, then success
        n0 = n_ed;
        start_req(3'b101);
        repeat (2) begin
            wait_tx("retry_ed", 8'hED);
            send_rx(8'hFE);
        end
        wait_tx("retry_ed_last", 8'hED);
        send_rx(8'hFA);
        wait_tx("retry_arg", 8'h05);
        send_rx(8'hFA);
        check("retry_done", {30'h0, led_done, led_busy}, 32'h2);
        check("retry_ed_count", n_ed - n0, 32'd3);
        tick();

        // Retries exhausted on the fourth 0xFE
        n0 = n_ed;
        start_req(3'b001);
        repeat (4) begin
            wait_tx("exhaust_ed", 8'hED);
            send_rx(8'hFE);
        end
        check("exhaust_err", {29'h0, led_err, led_done, led_busy}, 32'h4);
        check("exhaust_ed_count", n_ed - n0, 32'd4);
        tick();
        check("exhaust_err_pulse", {31'h0, led_err}, 32'h0);

        // Timeout exactly TO cycles after the 0xED accept
        start_req(3'b010);
        wait_tx("to_ed", 8'hED);
        err_early = 1'b0;
        for (int k = 1; k < TO; k++) begin
            if (led_err) err_early = 1'b1;
            tick();
        end
        check("to_no_early_err", {31'h0, err_early}, 32'h0);
        tick();
        check("to_err", {30'h0, led_err, led_busy}, 32'h2);
        tick();
        check("to_err_pulse", {31'h0, led_err}, 32'h0);

        // Reply in the final cycle beats the timeout
        start_req(3'b110);
        wait_tx("late_ed", 8'hED);
        for (int k = 1; k < TO; k++) tick();
        send_rx(8'hFA);
        check("late_no_err", {31'h0, led_err}, 32'h0);
        wait_tx("late_arg", 8'h06);
        send_rx(8'hFA);
        check("late_done", {30'h0, led_done, led_err}, 32'h2);
        tick();

        // Transmitter stalled longer than the timeout
        tx_ready = 1'b0;
        start_req(3'b100);
        stable = 1'b1;
        repeat (50) begin
            if (!(tx_valid && tx_data == 8'hED && !led_err)) stable = 1'b0;
            tick();
        end
        check("stall_hold", {31'h0, stable}, 32'h1);
        tx_ready = 1'b1;
        wait_tx("stall_ed", 8'hED);
        send_rx(8'hFA);
        wait_tx("stall_arg", 8'h04);
        tick();

        // Reset while waiting for the second ACK
        reset_n = 1'b0;
        #1;
        check("rst_mid_async", {28'h0, tx_valid, led_busy, led_done, led_err}, 32'h0);
        tick();
        tick();
        check("rst_mid_held", {28'h0, tx_valid, led_busy, led_done, led_err}, 32'h0);
        reset_n = 1'b1;
        tick();
        check("rst_mid_after", {28'h0, tx_valid, led_busy, led_done, led_err}, 32'h0);
        post_reset();
        send_rx(8'hFA);
        check("rst_idle_fwd", {22'h0, led_done, fwd_valid, fwd_data}, {22'h0, 2'b01, 8'hFA});
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
